// File: rtl/tesla_car_pkg.sv
// tesla_car_pkg
//   Shared definitions for the tesla_car longitudinal controller:
//   - state_t : 2-bit state encoding (STOP, ACCELERATE, DECELERATE; 2'b11 unused)
//   - MIN_DISTANCE_DEFAULT : default minimum safe leading distance
package tesla_car_pkg;

  typedef enum logic [1:0] {
    STOP       = 2'b00,
    ACCELERATE = 2'b01,
    DECELERATE = 2'b10
  } state_t;

  localparam int unsigned MIN_DISTANCE_DEFAULT = 40;

endpackage

// File: rtl/tesla_car.sv
// tesla_car
//   Moore FSM for longitudinal control. Each rising edge it compares car
//   speed against the speed limit and the leading distance against a
//   minimum safe distance, and steps between STOP, ACCELERATE and DECELERATE.
//
// Parameters
//   MIN_DISTANCE      minimum safe leading distance (same units as leading_distance)
// Ports
//   speed_limit       in  [7:0]  posted speed limit, unsigned
//   car_speed         in  [7:0]  current car speed, unsigned
//   leading_distance  in  [6:0]  distance to leading vehicle, unsigned
//   clk               in         system clock, rising edge
//   rst               in         asynchronous active-high reset, forces STOP
//   unlock_door       out        high only in STOP
//   accelerate_car    out        high only in ACCELERATE
//   state_o           out [1:0]  current state encoding; present only when
//                                TESLA_CAR_STATE_OUT_EN is defined
//
// State table
//   state      | meaning
//   STOP       | vehicle halted, doors unlocked
//   ACCELERATE | speed below limit with safe headroom, throttle applied
//   DECELERATE | coasting/braking until safe and below limit, or stopped
//   (2'b11)    | illegal, recovers to STOP on the next edge
module tesla_car
  import tesla_car_pkg::*;
#(
  parameter int unsigned MIN_DISTANCE = MIN_DISTANCE_DEFAULT
) (
  input  logic [7:0] speed_limit,
  input  logic [7:0] car_speed,
  input  logic [6:0] leading_distance,
  input  logic       clk,
  input  logic       rst,
  output logic       unlock_door,
`ifdef TESLA_CAR_STATE_OUT_EN
  output logic       accelerate_car,
  output logic [1:0] state_o
`else
  output logic       accelerate_car
`endif
);

  state_t state, state_nxt;
  logic   too_close;
  logic   below_limit;

  // Zero-extend the 7-bit distance to the parameter width before comparing.
  assign too_close   = 32'(leading_distance) < MIN_DISTANCE;
  assign below_limit = car_speed < speed_limit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= STOP;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = STOP;
    case (state)
      STOP: begin
        if (too_close)        state_nxt = STOP;
        else if (below_limit) state_nxt = ACCELERATE;
        else                  state_nxt = STOP;
      end
      ACCELERATE: begin
        if (too_close)        state_nxt = DECELERATE;
        else if (below_limit) state_nxt = ACCELERATE;
        else                  state_nxt = DECELERATE;
      end
      DECELERATE: begin
        // A standstill wins over every other condition.
        if (car_speed == 8'd0) state_nxt = STOP;
        else if (too_close)    state_nxt = DECELERATE;
        else if (below_limit)  state_nxt = ACCELERATE;
        else                   state_nxt = DECELERATE;
      end
      default: state_nxt = STOP;
    endcase
  end

  // Outputs decode the state register only, so they cannot glitch on inputs.
  always_comb begin
    unlock_door    = 1'b0;
    accelerate_car = 1'b0;
    case (state)
      STOP:       unlock_door    = 1'b1;
      ACCELERATE: accelerate_car = 1'b1;
      default:    ;
    endcase
  end

`ifdef TESLA_CAR_STATE_OUT_EN
  assign state_o = state;
`endif

endmodule

// File: tb/tb_tesla_car.sv
// tb_tesla_car
//   Directed, table-driven bench for tesla_car plus hand-written sequences
//   for reset behaviour. Checks state_o too when TESLA_CAR_STATE_OUT_EN is
//   defined.
module tb_tesla_car;

  logic [7:0] speed_limit;
  logic [7:0] car_speed;
  logic [6:0] leading_distance;
  logic       clk;
  logic       rst;
  logic       unlock_door;
  logic       accelerate_car;
`ifdef TESLA_CAR_STATE_OUT_EN
  logic [1:0] state_o;
`endif

  int errors = 0;
  int checks = 0;

  tesla_car #(.MIN_DISTANCE(40)) dut (
    .speed_limit      (speed_limit),
    .car_speed        (car_speed),
    .leading_distance (leading_distance),
    .clk              (clk),
    .rst              (rst),
    .unlock_door      (unlock_door),
`ifdef TESLA_CAR_STATE_OUT_EN
    .accelerate_car   (accelerate_car),
    .state_o          (state_o)
`else
    .accelerate_car   (accelerate_car)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] sl;
    logic [7:0] cs;
    logic [6:0] ld;
    logic [1:0] st;   // expected state after the edge: 0 STOP, 1 ACC, 2 DEC
  } vec_t;

  vec_t vecs [19];

  task automatic check_out(input string name, input logic [1:0] exp_st);
    logic exp_unlock, exp_accel;
    exp_unlock = (exp_st == 2'd0);
    exp_accel  = (exp_st == 2'd1);
    checks++;
    if (unlock_door !== exp_unlock || accelerate_car !== exp_accel) begin
      errors++;
      $display("FAIL %s: unlock_door=%b accelerate_car=%b, required %b %b",
               name, unlock_door, accelerate_car, exp_unlock, exp_accel);
    end
`ifdef TESLA_CAR_STATE_OUT_EN
    checks++;
    if (state_o !== exp_st) begin
      errors++;
      $display("FAIL %s state_o: got %b, required %b", name, state_o, exp_st);
    end
`endif
  endtask

  initial begin
    // {speed_limit, car_speed, leading_distance, expected state}
    vecs[0]  = '{8'd0,   8'd0,   7'd30,  2'd0}; // too close in STOP
    vecs[1]  = '{8'd0,   8'd0,   7'd50,  2'd0}; // no headroom
    vecs[2]  = '{8'd30,  8'd10,  7'd50,  2'd1}; // accelerate
    vecs[3]  = '{8'd30,  8'd10,  7'd20,  2'd2}; // obstacle
    vecs[4]  = '{8'd30,  8'd10,  7'd20,  2'd2}; // holds
    vecs[5]  = '{8'd30,  8'd0,   7'd20,  2'd0}; // stopped -> STOP
    vecs[6]  = '{8'd30,  8'd10,  7'd40,  2'd1}; // distance == MIN is safe
    vecs[7]  = '{8'd30,  8'd30,  7'd40,  2'd2}; // speed == limit
    vecs[8]  = '{8'd30,  8'd30,  7'd40,  2'd2}; // DEC holds at limit
    vecs[9]  = '{8'd30,  8'd20,  7'd100, 2'd1}; // DEC -> ACC
    vecs[10] = '{8'd30,  8'd29,  7'd100, 2'd1}; // ACC holds
    vecs[11] = '{8'd50,  8'd0,   7'd39,  2'd2}; // distance MIN-1 too close
    vecs[12] = '{8'd50,  8'd0,   7'd39,  2'd0}; // speed 0 beats too_close
    vecs[13] = '{8'd0,   8'd0,   7'd127, 2'd0}; // limit 0 never accelerates
    vecs[14] = '{8'd10,  8'd10,  7'd127, 2'd0}; // equal speed stays STOP
    vecs[15] = '{8'd255, 8'd254, 7'd127, 2'd1}; // wide values
    vecs[16] = '{8'd0,   8'd5,   7'd127, 2'd2}; // limit dropped to 0
    vecs[17] = '{8'd200, 8'd5,   7'd0,   2'd2}; // too close holds DEC
    vecs[18] = '{8'd30,  8'd10,  7'd50,  2'd1}; // back to ACC

    rst = 1'b1;
    speed_limit = '0;
    car_speed = '0;
    leading_distance = '0;
    repeat (50) @(posedge clk);
    #1;
    check_out("reset_hold", 2'd0);

    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      speed_limit      = vecs[i].sl;
      car_speed        = vecs[i].cs;
      leading_distance = vecs[i].ld;
      @(posedge clk);
      #1;
      check_out($sformatf("vec%0d", i), vecs[i].st);
    end

    // Asynchronous reset from ACCELERATE, checked before any further edge.
    #2;
    rst = 1'b1;
    #1;
    check_out("async_reset", 2'd0);
    @(posedge clk);
    #1;
    check_out("reset_held_edge", 2'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_out("after_reset_acc", 2'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
